// File: rtl/acc_seq_pkg.sv
// Shared opcodes, ALU select codes and sequencer state encoding for acc_sequencer.
package acc_seq_pkg;

    typedef logic [2:0] op_t;
    typedef logic [1:0] sel_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_CLR   = 3'd1;
    localparam op_t OP_LOAD  = 3'd2;
    localparam op_t OP_ADD   = 3'd3;
    localparam op_t OP_ADDC  = 3'd4;
    localparam op_t OP_NOT   = 3'd5;
    localparam op_t OP_AND   = 3'd6;
    localparam op_t OP_STORE = 3'd7;

    localparam sel_t SEL_CLR = 2'd0;
    localparam sel_t SEL_ADD = 2'd1;
    localparam sel_t SEL_NOT = 2'd2;
    localparam sel_t SEL_AND = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    function automatic logic is_alu_op(input op_t op);
        return (op == OP_CLR) || (op == OP_ADD) || (op == OP_ADDC) ||
               (op == OP_NOT) || (op == OP_AND);
    endfunction

    function automatic sel_t op_to_sel(input op_t op);
        case (op)
            OP_ADD, OP_ADDC: return SEL_ADD;
            OP_NOT:          return SEL_NOT;
            OP_AND:          return SEL_AND;
            default:         return SEL_CLR;
        endcase
    endfunction

endpackage

// File: rtl/acc_sequencer_if.sv
// Command and result handshake bundle between a command source and acc_sequencer.
interface acc_sequencer_if
    import acc_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    op_t               cmd_op;
    logic [DATA_W-1:0] cmd_operand;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_operand, res_ready,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_operand, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/acc_sequencer.sv
// Accumulator command sequencer: drives the registered ALU, writes back acc/carry,
// and returns STORE results over the result handshake.
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    acc_sequencer_if.slave    bus,
    output logic [DATA_W-1:0] alu_acc,
    output logic [DATA_W-1:0] alu_din,
    output logic              alu_cin,
    output sel_t              alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] acc_q,
    output logic              carry_q,
    output logic              busy
);

    state_t          state, state_nxt;
    logic            accept;
    logic            local_carry;
    logic [DATA_W:0] sum_ext;

    // Carry is rebuilt from the latched operands; the ALU's own carry is not trusted.
    assign sum_ext     = {1'b0, alu_acc} + {1'b0, alu_din} + {{DATA_W{1'b0}}, alu_cin};
    assign local_carry = (sum_ext >> DATA_W) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        busy          = 1'b1;
        accept        = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
                accept        = bus.cmd_valid;
                if (accept) begin
                    if (is_alu_op(bus.cmd_op))       state_nxt = ST_EXEC;
                    else if (bus.cmd_op == OP_STORE) state_nxt = ST_OUT;
                end
            end
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            ST_OUT:  if (bus.res_valid && bus.res_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            carry_q       <= 1'b0;
            alu_acc       <= '0;
            alu_din       <= '0;
            alu_cin       <= 1'b0;
            alu_sel       <= SEL_CLR;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.cmd_op == OP_LOAD) begin
                            acc_q <= bus.cmd_operand;
                        end else if (bus.cmd_op == OP_STORE) begin
                            bus.res_data  <= acc_q;
                            bus.res_valid <= 1'b1;
                        end else if (is_alu_op(bus.cmd_op)) begin
                            alu_acc <= acc_q;
                            alu_din <= bus.cmd_operand;
                            alu_sel <= op_to_sel(bus.cmd_op);
                            alu_cin <= (bus.cmd_op == OP_ADDC) ? carry_q : 1'b0;
                        end
                    end
                end
                // alu_sel is held through WB, so it identifies the op being retired.
                ST_WB: begin
                    acc_q   <= alu_out;
                    carry_q <= (alu_sel == SEL_ADD) ? local_carry : 1'b0;
                end
                ST_OUT: begin
                    if (bus.res_ready) bus.res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// Randomized self-checking bench for acc_sequencer with a registered ALU model and
// a transaction-level accumulator/carry reference.
module tb_acc_sequencer;
    import acc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_acc, alu_din, alu_out = '0, acc_q;
    logic        alu_cin, carry_q, busy;
    logic [1:0]  alu_sel;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] m_acc   = '0;
    logic        m_carry = 1'b0;

    acc_sequencer_if #(.DATA_W(32)) bus ();

    acc_sequencer #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .alu_acc (alu_acc),
        .alu_din (alu_din),
        .alu_cin (alu_cin),
        .alu_sel (alu_sel),
        .alu_out (alu_out),
        .acc_q   (acc_q),
        .carry_q (carry_q),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // External ALU: one registered stage, deliberately not reset.
    always @(posedge clk) begin
        case (alu_sel)
            2'd0: alu_out <= '0;
            2'd1: alu_out <= alu_acc + alu_din + {31'd0, alu_cin};
            2'd2: alu_out <= ~alu_acc;
            default: alu_out <= alu_acc & alu_din;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_sel(input logic [2:0] op);
        case (op)
            3'd3, 3'd4: return 2'd1;
            3'd5:       return 2'd2;
            3'd6:       return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [31:0] opnd);
        logic [32:0] t;
        case (op)
            3'd1: begin m_acc = '0; m_carry = 1'b0; end
            3'd2: m_acc = opnd;
            3'd3: begin t = {1'b0, m_acc} + {1'b0, opnd}; m_acc = t[31:0]; m_carry = t[32]; end
            3'd4: begin t = {1'b0, m_acc} + {1'b0, opnd} + {32'd0, m_carry};
                        m_acc = t[31:0]; m_carry = t[32]; end
            3'd5: begin m_acc = ~m_acc; m_carry = 1'b0; end
            3'd6: begin m_acc = m_acc & opnd; m_carry = 1'b0; end
            default: ;
        endcase
    endtask

    task automatic check_alu_held(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] s, input logic c);
        check("alu_acc", alu_acc, a);
        check("alu_din", alu_din, d);
        check("alu_sel", {30'd0, alu_sel}, {30'd0, s});
        check("alu_cin", {31'd0, alu_cin}, {31'd0, c});
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] opnd, input int unsigned hold);
        logic [31:0] prev_acc;
        logic        prev_c;
        int unsigned waited;
        waited = 0;
        while (!bus.cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            check("ready_timeout", {31'd0, bus.cmd_ready}, 32'd1);
            return;
        end
        prev_acc        = m_acc;
        prev_c          = m_carry;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_operand = opnd;
        @(negedge clk);
        bus.cmd_valid   = 1'b0;
        bus.cmd_operand = $urandom;
        model_apply(op, opnd);
        if (op == 3'd0 || op == 3'd2) begin
            check("single_acc", acc_q, m_acc);
            check("single_carry", {31'd0, carry_q}, {31'd0, m_carry});
            check("single_ready", {31'd0, bus.cmd_ready}, 32'd1);
        end else if (op == 3'd7) begin
            check("st_valid", {31'd0, bus.res_valid}, 32'd1);
            check("st_data", bus.res_data, m_acc);
            check("st_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
            for (int unsigned i = 0; i < hold; i++) begin
                @(negedge clk);
                check("st_hold_valid", {31'd0, bus.res_valid}, 32'd1);
                check("st_hold_data", bus.res_data, m_acc);
                check("st_hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
            end
            bus.res_ready = 1'b1;
            @(negedge clk);
            bus.res_ready = 1'b0;
            check("st_done_valid", {31'd0, bus.res_valid}, 32'd0);
            check("st_done_ready", {31'd0, bus.cmd_ready}, 32'd1);
        end else begin
            check_alu_held(prev_acc, opnd, exp_sel(op), (op == 3'd4) ? prev_c : 1'b0);
            check("exec_ready", {31'd0, bus.cmd_ready}, 32'd0);
            check("exec_busy", {31'd0, busy}, 32'd1);
            check("exec_acc", acc_q, prev_acc);
            @(negedge clk);
            check_alu_held(prev_acc, opnd, exp_sel(op), (op == 3'd4) ? prev_c : 1'b0);
            check("wb_ready", {31'd0, bus.cmd_ready}, 32'd0);
            check("wb_acc", acc_q, prev_acc);
            @(negedge clk);
            check("ret_acc", acc_q, m_acc);
            check("ret_carry", {31'd0, carry_q}, {31'd0, m_carry});
            check("ret_ready", {31'd0, bus.cmd_ready}, 32'd1);
            check("ret_alu_acc", alu_acc, prev_acc);
        end
    endtask

    initial begin
        int unsigned accepts;
        logic [31:0] last;
        logic [2:0]  rop;
        logic [31:0] ropnd;

        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'd0;
        bus.cmd_operand = '0;
        bus.res_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_acc", acc_q, 32'd0);
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_acc_rel", acc_q, 32'd0);
        check("rst_carry", {31'd0, carry_q}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_alu", {alu_acc ^ alu_din, alu_sel, alu_cin} == '0 ? 32'd0 : 32'd1, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        issue(3'd2, 32'd10, 0);
        issue(3'd3, 32'd10, 0);
        check("add10", acc_q, 32'd20);
        issue(3'd2, 32'hFFFF_FFFF, 0);
        issue(3'd3, 32'd1, 0);
        check("wrap_carry", {31'd0, carry_q}, 32'd1);
        issue(3'd4, 32'd0, 0);
        check("addc_acc", acc_q, 32'd1);
        issue(3'd2, 32'hACA6_ADB6, 0);
        issue(3'd5, 32'd0, 0);
        check("not_acc", acc_q, 32'h5359_5249);
        issue(3'd2, 32'hACA6_ADB6, 0);
        issue(3'd6, 32'hACA6_ACA6, 0);
        check("and_acc", acc_q, 32'hACA6_ACA6);
        issue(3'd2, 32'h1234, 0);
        issue(3'd7, 32'd0, 3);
        issue(3'd7, 32'd0, 0);

        // Back-to-back LOADs with cmd_valid held.
        accepts = 0;
        last    = '0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd2;
        for (int unsigned i = 0; i < 4; i++) begin
            last = $urandom;
            bus.cmd_operand = last;
            if (bus.cmd_ready) accepts++;
            @(negedge clk);
            check("b2b_acc", acc_q, last);
        end
        bus.cmd_valid = 1'b0;
        check("b2b_count", accepts, 32'd4);
        m_acc = last;

        // Reset while the ADD is in WB: the ALU result must be dropped.
        issue(3'd2, 32'd5, 0);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = 3'd3;
        bus.cmd_operand = 32'd7;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_acc", acc_q, 32'd0);
        check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_acc", acc_q, 32'd0);
        check("post_rst_carry", {31'd0, carry_q}, 32'd0);
        check("post_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        m_acc   = '0;
        m_carry = 1'b0;

        for (int unsigned n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       ropnd = 32'hFFFF_FFFF;
                1:       ropnd = 32'd0;
                default: ropnd = $urandom;
            endcase
            issue(rop, ropnd, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
